// File: rtl/nes_joypad_port_if.sv
// Bus bundle between the NES CPU I/O logic / report decoders and the
// joypad port emulation.
//   i_btn0/i_btn1 : button state per port {R,L,D,U,Start,Select,B,A}, 1 = pressed
//   i_strobe      : bit0 of the last CPU write to $4016 (level)
//   i_rd0/i_rd1   : high while the CPU reads $4016 / $4017
//   o_d0/o_d1     : current serial bit per port
//   o_cnt0/o_cnt1 : shifts since last load, saturating at 8
// master = CPU side (drives buttons/strobe/reads), slave = joypad port.
interface nes_joypad_port_if;
  logic [7:0] i_btn0;
  logic [7:0] i_btn1;
  logic       i_strobe;
  logic       i_rd0;
  logic       i_rd1;
  logic       o_d0;
  logic       o_d1;
  logic [3:0] o_cnt0;
  logic [3:0] o_cnt1;

  modport master (
    output i_btn0, i_btn1, i_strobe, i_rd0, i_rd1,
    input  o_d0, o_d1, o_cnt0, o_cnt1
  );

  modport slave (
    input  i_btn0, i_btn1, i_strobe, i_rd0, i_rd1,
    output o_d0, o_d1, o_cnt0, o_cnt1
  );
endinterface

// File: rtl/nes_joypad_port.sv
// Emulates two 4021-style NES controllers as seen at $4016/$4017.
// Button state is registered, optionally cleaned of impossible D-pad
// combinations, loaded into an 8-bit shift register while strobe is high,
// and shifted one bit (A first) at the end of every read access.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : buttons, strobe, read levels in; serial data and
//                    shift counts out
module nes_joypad_port #(
  parameter bit c_mask_opposite = 1'b1,
  parameter bit c_fill          = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  nes_joypad_port_if.slave bus
);

  localparam int NUM_PORTS = 2;

  logic [NUM_PORTS-1:0][7:0] btn;
  logic [NUM_PORTS-1:0]      rd;
  logic [NUM_PORTS-1:0]      d;
  logic [NUM_PORTS-1:0][3:0] cnt;

  assign btn = {bus.i_btn1, bus.i_btn0};
  assign rd  = {bus.i_rd1, bus.i_rd0};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [7:0] btn_m;
    logic [7:0] r_btn;
    logic       r_rd;
    logic [7:0] shreg;
    logic [3:0] cnt_q;
    logic       rd_fall;

    // Bit map: 0=A 1=B 2=Select 3=Start 4=U 5=D 6=L 7=R.
    // Opposing D-pad directions held together cancel out, since games
    // can misbehave when they see them simultaneously.
    always_comb begin
      btn_m = btn[p];
      if (c_mask_opposite) begin
        if (btn[p][4] && btn[p][5]) btn_m[5:4] = 2'b00;
        if (btn[p][6] && btn[p][7]) btn_m[7:6] = 2'b00;
      end
    end

    // The shift happens when a read completes, so a multi-cycle read
    // still advances exactly one bit.
    assign rd_fall = r_rd & ~rd[p];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_btn <= 8'h00;
        r_rd  <= 1'b0;
        shreg <= 8'h00;
        cnt_q <= 4'd0;
      end else begin
        r_btn <= btn_m;
        r_rd  <= rd[p];
        // Strobe keeps the register transparent to the buttons and
        // swallows any read ending in the same cycle.
        if (bus.i_strobe) begin
          shreg <= r_btn;
          cnt_q <= 4'd0;
        end else if (rd_fall) begin
          shreg <= {c_fill, shreg[7:1]};
          cnt_q <= (cnt_q == 4'd8) ? 4'd8 : cnt_q + 4'd1;
        end
      end
    end

    assign d[p]   = shreg[0];
    assign cnt[p] = cnt_q;
  end

  assign bus.o_d0   = d[0];
  assign bus.o_d1   = d[1];
  assign bus.o_cnt0 = cnt[0];
  assign bus.o_cnt1 = cnt[1];

endmodule

// File: tb/tb_nes_joypad_port.sv
module tb_nes_joypad_port;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] btn0, btn1;
  logic       strobe, rd0, rd1;
  int         n_pass = 0, n_tot = 0;
  bit         chk_en = 1'b0;

  always #5 clk = ~clk;

  // bus_m: default masking; bus_n: masking disabled. Same stimulus.
  nes_joypad_port_if bus_m ();
  nes_joypad_port_if bus_n ();

  assign bus_m.i_btn0 = btn0;   assign bus_n.i_btn0 = btn0;
  assign bus_m.i_btn1 = btn1;   assign bus_n.i_btn1 = btn1;
  assign bus_m.i_strobe = strobe; assign bus_n.i_strobe = strobe;
  assign bus_m.i_rd0 = rd0;     assign bus_n.i_rd0 = rd0;
  assign bus_m.i_rd1 = rd1;     assign bus_n.i_rd1 = rd1;

  nes_joypad_port dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_m));
  nes_joypad_port #(.c_mask_opposite(1'b0), .c_fill(1'b1)) dut_nm (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_n));

  // Model: per lane (inst*2+port) keep the byte captured at the last
  // strobe cycle and how many completed reads happened since.
  // The current bit is simply byte[k] for k<8, else the fill bit.
  logic [7:0] m_rbtn[4];
  logic [7:0] m_load[4];
  int         m_k[4];
  logic       m_rdp[2];

  function automatic logic [7:0] clean(input logic [7:0] b, input bit en);
    logic [7:0] r = b;
    if (en && b[4] && b[5]) begin r[4] = 1'b0; r[5] = 1'b0; end
    if (en && b[6] && b[7]) begin r[6] = 1'b0; r[7] = 1'b0; end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < 4; l++) begin
        m_rbtn[l] <= 8'h00; m_load[l] <= 8'h00; m_k[l] <= 0;
      end
      m_rdp[0] <= 1'b0; m_rdp[1] <= 1'b0;
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (strobe) begin
          m_load[l] <= m_rbtn[l];
          m_k[l]    <= 0;
        end else if (m_rdp[l % 2] && !((l % 2) ? rd1 : rd0)) begin
          m_k[l] <= (m_k[l] < 8) ? m_k[l] + 1 : 8;
        end
        m_rbtn[l] <= clean((l % 2) ? btn1 : btn0, l < 2);
      end
      m_rdp[0] <= rd0; m_rdp[1] <= rd1;
    end
  end

  function automatic int exp_d(input int l);
    logic [7:0] b = m_load[l];
    return (m_k[l] < 8) ? int'(b[m_k[l]]) : 1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      int ad[4], ac[4];
      ad = '{int'(bus_m.o_d0), int'(bus_m.o_d1), int'(bus_n.o_d0), int'(bus_n.o_d1)};
      ac = '{int'(bus_m.o_cnt0), int'(bus_m.o_cnt1), int'(bus_n.o_cnt0), int'(bus_n.o_cnt1)};
      for (int l = 0; l < 4; l++) begin
        chk($sformatf("model_d lane%0d", l), ad[l], exp_d(l));
        chk($sformatf("model_cnt lane%0d", l), ac[l], m_k[l]);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [7:0] b0, input logic [7:0] b1, input int hold);
    btn0 = b0; btn1 = b1; tick();
    strobe = 1'b1; repeat (hold) tick();
    strobe = 1'b0; tick();
  endtask

  task automatic rd(input int port, input int hi);
    if (port == 0) rd0 = 1'b1; else rd1 = 1'b1;
    repeat (hi) tick();
    rd0 = 1'b0; rd1 = 1'b0; tick();
  endtask

  initial begin
    logic [7:0] e;
    rst_n = 1'b0; btn0 = 8'h00; btn1 = 8'h00; strobe = 1'b0; rd0 = 1'b0; rd1 = 1'b0;
    tick(); tick();
    chk("reset d0", bus_m.o_d0, 0);
    chk("reset cnt1", bus_m.o_cnt1, 0);
    rst_n = 1'b1; chk_en = 1'b1; tick();

    // All released: eight zeros then fill ones; count saturates.
    load(8'h00, 8'h00, 2);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("zero seq bit%0d", i), bus_m.o_d0, (i < 8) ? 0 : 1);
      rd(0, 3);
    end
    chk("zero seq cnt0 sat", bus_m.o_cnt0, 8);

    // Select+A.
    load(8'h05, 8'h00, 4);
    e = 8'b0000_0101;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("selA bit%0d", i), bus_m.o_d0, int'(e[i]));
      rd(0, 3);
    end
    chk("selA cnt1 idle", bus_m.o_cnt1, 0);
    chk("selA d1 idle", bus_m.o_d1, 0);

    // Full D-pad on port 1: masked vs unmasked.
    load(8'h00, 8'hF0, 2);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("dpad masked bit%0d", i), bus_m.o_d1, 0);
      chk($sformatf("dpad unmasked bit%0d", i), bus_n.o_d1, (i >= 4) ? 1 : 0);
      rd(1, 2);
    end
    chk("dpad cnt0 idle", bus_m.o_cnt0, 0);

    // Button change after strobe falls must not reload.
    btn0 = 8'h01; tick(); strobe = 1'b1; tick(); tick(); strobe = 1'b0; tick();
    btn0 = 8'h02; tick(); tick(); tick();
    chk("late change first bit", bus_m.o_d0, 1);
    rd(0, 2);
    chk("late change second bit", bus_m.o_d0, 0);

    // Read ending while strobe is high: load wins, no shift.
    load(8'h01, 8'h00, 2);
    rd(0, 2); rd(0, 2);
    chk("pre-overlap cnt0", bus_m.o_cnt0, 2);
    rd0 = 1'b1; tick(); strobe = 1'b1; tick(); rd0 = 1'b0; tick();
    chk("overlap cnt0", bus_m.o_cnt0, 0);
    chk("overlap d0", bus_m.o_d0, 1);
    strobe = 1'b0; tick();
    chk("overlap cnt0 after", bus_m.o_cnt0, 0);

    // Async reset mid-sequence, then a clean full sequence.
    load(8'hA5, 8'h00, 2);
    rd(0, 2); rd(0, 2); rd(0, 2);
    chk("pre-reset cnt0", bus_m.o_cnt0, 3);
    rst_n = 1'b0; #2;
    chk("async reset d0", bus_m.o_d0, 0);
    chk("async reset cnt0", bus_m.o_cnt0, 0);
    tick(); tick(); rst_n = 1'b1; tick();
    load(8'hA5, 8'h00, 2);
    e = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("post-reset bit%0d", i), bus_m.o_d0, int'(e[i]));
      rd(0, 2);
    end

    // Random traffic, including occasional mid-cycle resets.
    for (int c = 0; c < 2000; c++) begin
      btn0   = 8'($urandom);
      btn1   = 8'($urandom);
      strobe = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2) == 0) rd0 = ~rd0;
      if ($urandom_range(0, 2) == 0) rd1 = ~rd1;
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0; #3 rst_n = 1'b1;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
